qspi_flash_rd: RTL

Read-only quad-SPI flash controller that drives the devkit's `qspi_clk`, `qspi_csn` and `qspi_io[3:0]` pins. Each request fetches one 32-bit word from serial flash using the Fast Read Quad I/O command (0xEB). The block sits between an on-chip requester (boot loader or irom refill logic) and the board-level tri-state buffers. The tri-states live at the top level: `qspi_io[i] = QSPI_IO_OE[i] ? QSPI_IO_OUT[i] : 1'bz`.

---
 rtl/qspi_flash_rd_if.sv | 12 +
 rtl/qspi_flash_rd.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/qspi_flash_rd_if.sv
// Request-side bus of the quad-SPI flash reader: one-word read request in,
// busy/valid/data back to the requester.
interface qspi_flash_rd_if;
  logic        REQ;
  logic [23:0] ADDR;
  logic        BUSY;
  logic        VALID;
  logic [31:0] RDATA;

  modport master (output REQ, ADDR, input BUSY, VALID, RDATA);
  modport slave  (input REQ, ADDR, output BUSY, VALID, RDATA);
endinterface

// File: rtl/qspi_flash_rd.sv
// Read-only quad-SPI flash controller: one 32-bit word per request using
// Fast Read Quad I/O (0xEB), SPI mode 0, little-endian result.
module qspi_flash_rd #(
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  qspi_flash_rd_if.slave       bus,
  output logic                 QSPI_CLK,
  output logic                 QSPI_CSN,
  output logic [3:0]           QSPI_IO_OUT,
  output logic [3:0]           QSPI_IO_OE,
  input  logic [3:0]           QSPI_IO_IN
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_CSH
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

  state_t      state_reg;
  logic [7:0]  div_cnt_reg;
  logic [3:0]  sck_cnt_reg;
  logic [31:0] shift_reg;
  logic [3:0]  phase_last;
  logic        div_tick;
  logic        phase_done;

  always_comb begin
    phase_last = 4'd7;
    case (state_reg)
      S_ADDR:  phase_last = 4'd5;
      S_MODE:  phase_last = 4'd1;
      S_DUMMY: phase_last = DUMMY_LAST;
      S_CSH:   phase_last = 4'd3;
      default: phase_last = 4'd7;
    endcase
  end

  assign div_tick   = (div_cnt_reg == DIV_LAST);
  assign phase_done = (sck_cnt_reg == phase_last);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= S_IDLE;
      div_cnt_reg <= '0;
      sck_cnt_reg <= '0;
      shift_reg   <= '0;
      QSPI_CLK    <= 1'b0;
      QSPI_CSN    <= 1'b1;
      QSPI_IO_OUT <= 4'h0;
      QSPI_IO_OE  <= 4'h0;
      bus.BUSY    <= 1'b0;
      bus.VALID   <= 1'b0;
      bus.RDATA   <= '0;
    end else begin
      bus.VALID <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.REQ) begin
            state_reg   <= S_CMD;
            QSPI_CSN    <= 1'b0;
            bus.BUSY    <= 1'b1;
            div_cnt_reg <= '0;
            sck_cnt_reg <= '0;
            // Bit 7 of 0xEB goes out now; the rest of the command and the
            // word-aligned address wait MSB-first in the shifter.
            shift_reg   <= {7'h6B, bus.ADDR & 24'hFFFFFC, 1'b0};
            QSPI_IO_OUT <= 4'b1101;
            QSPI_IO_OE  <= 4'b1101;
          end
        end
        S_CSH: begin
          div_cnt_reg <= div_tick ? 8'd0 : div_cnt_reg + 8'd1;
          if (div_tick) begin
            sck_cnt_reg <= sck_cnt_reg + 4'd1;
            if (phase_done) begin
              state_reg   <= S_IDLE;
              sck_cnt_reg <= '0;
              bus.BUSY    <= 1'b0;
            end
          end
        end
        default: begin
          div_cnt_reg <= div_tick ? 8'd0 : div_cnt_reg + 8'd1;
          if (div_tick) QSPI_CLK <= ~QSPI_CLK;
          // Falling SCK: sample input, present next output, advance phase.
          if (div_tick && QSPI_CLK) begin
            sck_cnt_reg <= phase_done ? 4'd0 : sck_cnt_reg + 4'd1;
            case (state_reg)
              S_CMD: begin
                if (phase_done) begin
                  state_reg   <= S_ADDR;
                  QSPI_IO_OUT <= shift_reg[31:28];
                  QSPI_IO_OE  <= 4'hF;
                  shift_reg   <= shift_reg << 4;
                end else begin
                  QSPI_IO_OUT <= {3'b110, shift_reg[31]};
                  shift_reg   <= shift_reg << 1;
                end
              end
              S_ADDR: begin
                if (phase_done) begin
                  state_reg   <= S_MODE;
                  QSPI_IO_OUT <= 4'h0;
                end else begin
                  QSPI_IO_OUT <= shift_reg[31:28];
                  shift_reg   <= shift_reg << 4;
                end
              end
              S_MODE: begin
                if (phase_done) begin
                  state_reg  <= S_DUMMY;
                  QSPI_IO_OE <= 4'h0;
                end
              end
              S_DUMMY: begin
                if (phase_done) state_reg <= S_DATA;
              end
              S_DATA: begin
                shift_reg <= {shift_reg[27:0], QSPI_IO_IN};
                if (phase_done) begin
                  state_reg <= S_CSH;
                  QSPI_CSN  <= 1'b1;
                  bus.VALID <= 1'b1;
                  // Bytes arrived in address order; first byte lands lowest.
                  bus.RDATA <= {shift_reg[3:0], QSPI_IO_IN, shift_reg[11:4],
                                shift_reg[19:12], shift_reg[27:20]};
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
